// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one completed functional-unit result per cycle
// and broadcasts it to the ROB and reservation stations, with round-robin or fixed priority.
module cdb_arbiter #(
  parameter int NUM_FU       = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_IX_WIDTH = 3,
  parameter int RR_MODE      = 1
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_FU-1:0]              fu_valid_in,
  input  logic [NUM_FU*ROB_IX_WIDTH-1:0] fu_rob_ix_in,
  input  logic [NUM_FU*DATA_WIDTH-1:0]   fu_data_in,
  input  logic                           flush_in,
  output logic [NUM_FU-1:0]              fu_read_out,
  output logic                           cdb_valid_out,
  output logic [ROB_IX_WIDTH-1:0]        cdb_rob_ix_out,
  output logic [DATA_WIDTH-1:0]          cdb_value_out,
  output logic [$clog2(NUM_FU)-1:0]      grant_ix_out
);

  localparam int IX_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]       mask;
  logic [NUM_FU-1:0]       eligible;
  logic [NUM_FU-1:0]       grant_oh;
  logic [IX_W-1:0]         rr_ptr;
  logic [IX_W-1:0]         win_ix;
  logic [IX_W-1:0]         next_ptr;
  logic                    win_found;
  logic [ROB_IX_WIDTH-1:0] win_rob_ix;
  logic [DATA_WIDTH-1:0]   win_data;

  // The channel granted last edge is masked because its FU cannot yet have
  // reacted to the read pulse; without this it would be broadcast twice.
  assign eligible = fu_valid_in & ~mask;

  // Winner search: start at rr_ptr (round-robin) or at 0 (fixed priority),
  // ascending with wrap-around; first eligible channel wins.
  always_comb begin
    logic [IX_W-1:0] cand;
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    win_found = 1'b0;
    win_ix    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (RR_MODE != 0) begin
        cand = IX_W'((int'(rr_ptr) + k) % NUM_FU);
      end else begin
        cand = IX_W'(k);
      end
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_ix    = cand;
      end
    end
  end

  // Field mux for the winning channel, using constant slices per channel.
  always_comb begin
    win_rob_ix = '0;
    win_data   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (win_ix == IX_W'(k)) begin
        win_rob_ix = fu_rob_ix_in[k*ROB_IX_WIDTH +: ROB_IX_WIDTH];
        win_data   = fu_data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant_oh = {{(NUM_FU-1){1'b0}}, 1'b1} << win_ix;
  assign next_ptr = (win_ix == IX_W'(NUM_FU - 1)) ? '0 : win_ix + 1'b1;

  // Reset beats flush, flush beats any request. Broadcast fields hold when idle.
  always_ff @(posedge clk_in) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst_in) begin
      fu_read_out    <= '0;
      cdb_valid_out  <= 1'b0;
      cdb_rob_ix_out <= '0;
      cdb_value_out  <= '0;
      grant_ix_out   <= '0;
      mask           <= '0;
      rr_ptr         <= '0;
    end else if (flush_in || !win_found) begin
      fu_read_out   <= '0;
      cdb_valid_out <= 1'b0;
      mask          <= '0;
    end else begin
      fu_read_out    <= grant_oh;
      cdb_valid_out  <= 1'b1;
      cdb_rob_ix_out <= win_rob_ix;
      cdb_value_out  <= win_data;
      grant_ix_out   <= win_ix;
      mask           <= grant_oh;
      if (RR_MODE != 0) begin
        rr_ptr <= next_ptr;
      end
    end
  end

  // Simulation-only protocol properties on the read pulse.
  a_read_onehot : assert property (@(posedge clk_in) disable iff (rst_in)
    $onehot0(fu_read_out));
  a_read_no_repeat : assert property (@(posedge clk_in) disable iff (rst_in)
    (fu_read_out & $past(fu_read_out)) == '0);
  a_valid_matches_read : assert property (@(posedge clk_in) disable iff (rst_in)
    cdb_valid_out == (fu_read_out != '0));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: one round-robin and one fixed-priority instance, directed
// steps followed by random traffic, all checked against a behavioural model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 3;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Instance A: round-robin. Instance B: fixed priority.
  logic            a_rst, a_flush, b_rst, b_flush;
  logic [N-1:0]    a_valid, b_valid;
  logic [N*RW-1:0] a_rob, b_rob;
  logic [N*DW-1:0] a_data, b_data;
  logic [N-1:0]    a_read, b_read;
  logic            a_cdbv, b_cdbv;
  logic [RW-1:0]   a_cdbrob, b_cdbrob;
  logic [DW-1:0]   a_cdbval, b_cdbval;
  logic [1:0]      a_gix, b_gix;

  cdb_arbiter #(.NUM_FU(N), .DATA_WIDTH(DW), .ROB_IX_WIDTH(RW), .RR_MODE(1)) dut_rr (
    .clk_in(clk_in), .rst_in(a_rst), .fu_valid_in(a_valid), .fu_rob_ix_in(a_rob),
    .fu_data_in(a_data), .flush_in(a_flush), .fu_read_out(a_read), .cdb_valid_out(a_cdbv),
    .cdb_rob_ix_out(a_cdbrob), .cdb_value_out(a_cdbval), .grant_ix_out(a_gix));

  cdb_arbiter #(.NUM_FU(N), .DATA_WIDTH(DW), .ROB_IX_WIDTH(RW), .RR_MODE(0)) dut_fp (
    .clk_in(clk_in), .rst_in(b_rst), .fu_valid_in(b_valid), .fu_rob_ix_in(b_rob),
    .fu_data_in(b_data), .flush_in(b_flush), .fu_read_out(b_read), .cdb_valid_out(b_cdbv),
    .cdb_rob_ix_out(b_cdbrob), .cdb_value_out(b_cdbval), .grant_ix_out(b_gix));

  int errors = 0;
  int checks = 0;

  // Model state per instance (0 = round-robin, 1 = fixed priority).
  int m_ptr[2];
  int m_last[2];        // channel granted at the previous edge, -1 if none
  int m_valid[2];
  int m_rob[2];
  int m_val[2];
  int m_gix[2];
  int m_read[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the arbiter rules: reset, flush, then scan for a winner.
  task automatic model_step(input int d, input logic rst, input logic fl,
                            input logic [N-1:0] v, input logic [N*RW-1:0] rob,
                            input logic [N*DW-1:0] dat);
    int w;
    w = -1;
    if (rst) begin
      m_ptr[d] = 0; m_last[d] = -1; m_valid[d] = 0;
      m_rob[d] = 0; m_val[d] = 0; m_gix[d] = 0; m_read[d] = 0;
      return;
    end
    if (!fl) begin
      for (int k = 0; k < N; k++) begin
        int ch;
        ch = (d == 0) ? (m_ptr[d] + k) % N : k;
        if (w < 0 && v[ch] && ch != m_last[d]) w = ch;
      end
    end
    if (w < 0) begin
      m_valid[d] = 0; m_read[d] = 0; m_last[d] = -1;
    end else begin
      m_valid[d] = 1;
      m_rob[d]   = int'(rob[w*RW +: RW]);
      m_val[d]   = int'(dat[w*DW +: DW]);
      m_gix[d]   = w;
      m_read[d]  = 1 << w;
      m_last[d]  = w;
      if (d == 0) m_ptr[d] = (w + 1) % N;
    end
  endtask

  task automatic tick();
    model_step(0, a_rst, a_flush, a_valid, a_rob, a_data);
    model_step(1, b_rst, b_flush, b_valid, b_rob, b_data);
    @(posedge clk_in);
    #1;
    check("rr.valid", 32'(a_cdbv),   32'(m_valid[0]));
    check("rr.read",  32'(a_read),   32'(m_read[0]));
    check("rr.rob",   32'(a_cdbrob), 32'(m_rob[0]));
    check("rr.value", a_cdbval,      32'(m_val[0]));
    check("rr.gix",   32'(a_gix),    32'(m_gix[0]));
    check("rr.ptr",   32'(dut_rr.rr_ptr), 32'(m_ptr[0]));
    check("fp.valid", 32'(b_cdbv),   32'(m_valid[1]));
    check("fp.read",  32'(b_read),   32'(m_read[1]));
    check("fp.rob",   32'(b_cdbrob), 32'(m_rob[1]));
    check("fp.value", b_cdbval,      32'(m_val[1]));
    check("fp.gix",   32'(b_gix),    32'(m_gix[1]));
  endtask

  initial begin
    int saved_ptr;
    a_rst = 1'b1; b_rst = 1'b1; a_flush = 1'b0; b_flush = 1'b0;
    a_valid = '0; b_valid = '0;
    // Channel i carries rob_ix = i+3 and data = 0xA9+i, so channel 2 is (5, 0xAB).
    for (int i = 0; i < N; i++) begin
      a_rob[i*RW +: RW]  = RW'(i + 3);
      a_data[i*DW +: DW] = 32'hA9 + 32'(i);
    end
    b_rob = a_rob; b_data = a_data;
    tick(); tick();
    check("reset.valid", 32'(a_cdbv), 32'd0);
    check("reset.read",  32'(a_read), 32'd0);
    check("reset.value", a_cdbval,    32'd0);
    check("reset.gix",   32'(a_gix),  32'd0);
    a_rst = 1'b0; b_rst = 1'b0;

    // Single requester on channel 2.
    tick();
    a_valid = 4'b0100;
    tick();
    check("single.valid", 32'(a_cdbv),   32'd1);
    check("single.rob",   32'(a_cdbrob), 32'd5);
    check("single.value", a_cdbval,      32'h0000_00AB);
    check("single.gix",   32'(a_gix),    32'd2);
    check("single.read",  32'(a_read),   32'b0100);
    a_valid = '0;
    tick();
    check("single.idle_valid", 32'(a_cdbv), 32'd0);
    check("single.idle_read",  32'(a_read), 32'd0);

    // Mask: channel 1 holds valid one extra cycle after its read.
    a_valid = 4'b0010;
    tick();
    check("mask.first_read", 32'(a_read), 32'b0010);
    tick();
    check("mask.no_second_read",  32'(a_read), 32'd0);
    check("mask.no_second_valid", 32'(a_cdbv), 32'd0);
    a_valid = '0;

    // Fixed priority: channels 1 and 3, then 1 re-asserts alongside 3.
    b_valid = 4'b1010;
    tick();
    check("fp.first", 32'(b_gix), 32'd1);
    b_valid = 4'b1000;
    tick();
    check("fp.second", 32'(b_gix), 32'd3);
    b_valid = 4'b1010;
    tick();
    check("fp.reassert", 32'(b_gix), 32'd1);
    b_valid = '0;
    tick();

    // Flush with channels 0 and 2 pending.
    saved_ptr = m_ptr[0];
    a_valid = 4'b0101; a_flush = 1'b1;
    tick();
    check("flush.valid", 32'(a_cdbv), 32'd0);
    check("flush.read",  32'(a_read), 32'd0);
    check("flush.ptr",   32'(dut_rr.rr_ptr), 32'(saved_ptr));
    a_flush = 1'b0;
    tick();
    check("flush.resume", 32'(a_cdbv), 32'd1);
    a_valid = '0;
    tick();

    // Reset mid-broadcast, then round-robin fairness with all channels valid.
    a_valid = 4'b1111;
    tick();
    check("rst_mid.busy", 32'(a_cdbv), 32'd1);
    a_rst = 1'b1;
    tick();
    check("rst_mid.valid", 32'(a_cdbv),   32'd0);
    check("rst_mid.read",  32'(a_read),   32'd0);
    check("rst_mid.rob",   32'(a_cdbrob), 32'd0);
    check("rst_mid.value", a_cdbval,      32'd0);
    check("rst_mid.gix",   32'(a_gix),    32'd0);
    a_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr.order", 32'(a_gix),  32'(i % N));
      check("rr.pulse", 32'(a_read), 32'(1 << (i % N)));
      check("rr.busy",  32'(a_cdbv), 32'd1);
    end

    // Random traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      a_valid = N'($urandom);
      b_valid = N'($urandom);
      a_rob   = (N*RW)'($urandom);
      b_rob   = (N*RW)'($urandom);
      a_data  = {$urandom, $urandom, $urandom, $urandom};
      b_data  = {$urandom, $urandom, $urandom, $urandom};
      a_flush = ($urandom_range(15) == 0);
      b_flush = ($urandom_range(15) == 0);
      a_rst   = ($urandom_range(63) == 0);
      b_rst   = ($urandom_range(63) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Parametrised common-data-bus arbiter for the Tomasulo core.
- Collects completed results from NUM_FU functional units (ALU, branch ALU, MUL, DIV, MEM, ...) and broadcasts one result per cycle to the ROB and the reservation stations.
- Generalises the fixed two-unit, fixed-priority CDB write logic to N channels with selectable round-robin or fixed priority.
- Masks the just-granted channel for one cycle so a channel is never granted twice, and supports flush.

Parameters:
- NUM_FU, 4: number of functional-unit channels (2..8).
- DATA_WIDTH, 32: result value width.
- ROB_IX_WIDTH, 3: ROB index width.
- RR_MODE, 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- fu_valid_in  input  NUM_FU  per-channel result-valid; held high by the FU until it sees read
- fu_rob_ix_in  input  NUM_FU*ROB_IX_WIDTH  per-channel ROB index, channel i in bits [i*ROB_IX_WIDTH +: ROB_IX_WIDTH]
- fu_data_in  input  NUM_FU*DATA_WIDTH  per-channel result, channel i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- flush_in  input  1  pipeline flush; suppresses grants
- fu_read_out  output  NUM_FU  one-hot, one-cycle read pulse to the granted FU
- cdb_valid_out  output  1  CDB broadcast valid
- cdb_rob_ix_out  output  ROB_IX_WIDTH  broadcast ROB index
- cdb_value_out  output  DATA_WIDTH  broadcast value
- grant_ix_out  output  clog2(NUM_FU)  index of the channel driving the current broadcast

Behaviour:
- Reset values: all outputs 0; rr_ptr = 0; mask = 0.
- Eligible set each cycle: eligible = fu_valid_in & ~mask.
  - mask is the one-hot grant registered at the previous edge.
  - This covers the cycle in which the FU has not yet dropped valid in response to read.
- Arbitration is combinational over eligible; all outputs are registered.
  - Latency: request present in cycle c, broadcast visible in cycle c+1.
- RR_MODE=1: search starts at rr_ptr, ascending with wrap-around (NUM_FU-1 -> 0); the first eligible channel wins.
  - After a grant to channel w: rr_ptr <= (w+1) mod NUM_FU.
  - With no grant, rr_ptr holds.
- RR_MODE=0: the lowest-index eligible channel wins; rr_ptr is unused and stays 0.
- On a grant to w at the edge:
  - cdb_valid_out <= 1; cdb_rob_ix_out and cdb_value_out load channel w's fields; grant_ix_out <= w.
  - fu_read_out <= one-hot(w); mask <= one-hot(w).
- On no eligible channel:
  - cdb_valid_out <= 0; fu_read_out <= 0; mask <= 0.
  - cdb_rob_ix_out, cdb_value_out and grant_ix_out hold their previous values.
- fu_read_out is never high for two consecutive cycles on the same channel.
- Back-to-back grants on different channels are allowed every cycle.
- A channel whose valid is still high two cycles after a grant is treated as a new result. An FU must drop valid within one cycle of read.
- flush_in high at an edge: no grant; cdb_valid_out <= 0; fu_read_out <= 0; mask <= 0; rr_ptr holds.
  - Flush takes priority over any request.
- rst_in has priority over flush_in and over requests. Reset mid-broadcast clears cdb_valid_out at the same edge.
- No backpressure from the CDB: at most one result per cycle; losers keep valid high and retry.
- Starvation bound (RR_MODE=1): a continuously valid channel is granted within NUM_FU cycles.

Test Plan:
- Single requester: NUM_FU=4. Channel 2 asserts valid with rob_ix=5, data=0x0000_00AB from cycle 1 and drops it the cycle after read.
  - Expect at cycle 2: cdb_valid_out=1, rob_ix=5, value=0xAB, grant_ix_out=2, fu_read_out=4'b0100.
  - Expect at cycle 3: cdb_valid_out=0, fu_read_out=0.
- Mask check: channel 1 holds valid one extra cycle after read.
  - Expect exactly one read pulse and one broadcast for it, never two consecutive.
- Round-robin fairness: RR_MODE=1, all four channels hold valid continuously.
  - Expect grant order 0,1,2,3,0,1,... on consecutive cycles.
  - Expect cdb_valid_out high every cycle and each fu_read_out bit pulsing once per 4 cycles.
- Fixed priority: RR_MODE=0, channels 1 and 3 valid simultaneously.
  - Expect channel 1 granted first and channel 3 on the next cycle.
  - Then, if channel 1 re-asserts valid, it wins again over any later channel 3 request.
- Flush: channels 0 and 2 valid, flush_in high for one cycle.
  - Expect at the next edge: cdb_valid_out=0, fu_read_out=0, rr_ptr unchanged.
  - Expect arbitration to resume the cycle after flush drops.
- Reset mid-operation: assert rst_in while cdb_valid_out=1.
  - Expect at the next edge: all outputs 0.
  - Expect that after release with all four channels valid, channel 0 is granted first.
